// File: rtl/sync_rx_type1_if.sv
// Word-crossing bus for sync_rx_type1: sender-side request/data plus receiver-side results.
// master = sender/observer side, slave = the receiver block.
interface sync_rx_type1_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
);
    logic             req_async;
    logic [W-1:0]     data_async;
    logic             ack;
    logic [W-1:0]     out;
    logic             out_valid;
    logic [CNT_W-1:0] cnt;
    logic             err;

    modport master (
        output req_async, data_async,
        input  ack, out, out_valid, cnt, err
    );

    modport slave (
        input  req_async, data_async,
        output ack, out, out_valid, cnt, err
    );
endinterface

// File: rtl/sync_rx_type1.sv
// Receiving end of a four-phase req/ack word crossing into the clk_out domain.
// Optional ack timeout with sticky err is enabled by defining SYNC_RX_TIMEOUT_EN.
module sync_rx_type1 #(
    parameter int unsigned W       = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clk_out,
    input  logic           rst_out,
    sync_rx_type1_if.slave bus
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("TIMEOUT must be at least 2");
    end

`ifdef SYNC_RX_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {StIdle, StWaitLow, StStall} state_e;
`else
    typedef enum logic {StIdle, StWaitLow} state_e;
`endif

    state_e state_q, state_d;

    logic             req_s0_q, req_s1_q;
    logic             ack_q, ack_d;
    logic [W-1:0]     out_q, out_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SYNC_RX_TIMEOUT_EN
    logic             err_q, err_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk_out) begin
        if (rst_out) begin
            req_s0_q <= 1'b0;
            req_s1_q <= 1'b0;
            state_q  <= StIdle;
            ack_q    <= 1'b0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef SYNC_RX_TIMEOUT_EN
            err_q    <= 1'b0;
            tmo_q    <= '0;
`endif
        end else begin
            req_s0_q <= bus.req_async;
            req_s1_q <= req_s0_q;
            state_q  <= state_d;
            ack_q    <= ack_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
`ifdef SYNC_RX_TIMEOUT_EN
            err_q    <= err_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (req_s1_q) state_d = StWaitLow;
            StWaitLow: begin
                if (!req_s1_q) begin
                    state_d = StIdle;
`ifdef SYNC_RX_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d = StStall;
`endif
                end
            end
`ifdef SYNC_RX_TIMEOUT_EN
            StStall:   if (!req_s1_q) state_d = StIdle;
`endif
            default:   state_d = StIdle;
        endcase
    end

    // data_async is only sampled once req_s1 shows the sender is holding it stable.
    always_comb begin
        ack_d   = ack_q;
        out_d   = out_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
`ifdef SYNC_RX_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_s1_q) begin
                    out_d   = bus.data_async;
                    valid_d = 1'b1;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef SYNC_RX_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            StWaitLow: begin
                if (!req_s1_q) begin
                    ack_d = 1'b0;
`ifdef SYNC_RX_TIMEOUT_EN
                end else if (tmo_hit) begin
                    err_d = 1'b1;
                    ack_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
`endif
                end
            end
`ifdef SYNC_RX_TIMEOUT_EN
            StStall: ack_d = 1'b0;
`endif
            default: ack_d = 1'b0;
        endcase
    end

    assign bus.ack       = ack_q;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.cnt       = cnt_q;
`ifdef SYNC_RX_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_sync_rx_type1.sv
// Self-checking bench for sync_rx_type1: two instances (16-bit and 2-bit counters) share stimulus.
// A protocol-level model predicts every output each cycle; directed scenarios pin literal values.
module tb_sync_rx_type1;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] data = '0;

    int checks = 0;
    int errors = 0;

    sync_rx_type1_if #(.W(32), .CNT_W(16)) bus ();
    sync_rx_type1_if #(.W(32), .CNT_W(2))  bus_w ();

    assign bus.req_async    = req;
    assign bus.data_async   = data;
    assign bus_w.req_async  = req;
    assign bus_w.data_async = data;

    sync_rx_type1 #(.W(32), .CNT_W(16), .TIMEOUT(TO)) u_dut (
        .clk_out (clk),
        .rst_out (rst),
        .bus     (bus)
    );

    sync_rx_type1 #(.W(32), .CNT_W(2), .TIMEOUT(TO)) u_dut_w (
        .clk_out (clk),
        .rst_out (rst),
        .bus     (bus_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: the receiver sees req two edges late; one capture per request
    // level, ack dropped once the request is seen low (or after TO cycles held).
    logic        h0 = 0, h1 = 0, seen;
    bit          open = 0, stalled = 0;
    int          held = 0;
    logic        m_ack = 0, m_valid = 0, m_err = 0;
    logic [31:0] m_out = '0;
    int unsigned m_count = 0;

    always @(posedge clk) begin
        if (rst) begin
            h0 = 0; h1 = 0; open = 0; stalled = 0; held = 0;
            m_ack = 0; m_valid = 0; m_err = 0; m_out = '0; m_count = 0;
        end else begin
            seen = h1;
            h1 = h0;
            h0 = req;
            m_valid = 0;
            if (stalled) begin
                if (!seen) stalled = 0;
            end else if (!open) begin
                if (seen) begin
                    m_out = data; m_valid = 1; m_ack = 1; m_count++; open = 1; held = 0;
                end
            end else if (!seen) begin
                open = 0; m_ack = 0;
            end else begin
`ifdef SYNC_RX_TIMEOUT_EN
                held++;
                if (held == TO) begin
                    m_err = 1; m_ack = 0; open = 0; stalled = 1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("ack", bus.ack, m_ack);
        check("out", bus.out, m_out);
        check("out_valid", bus.out_valid, m_valid);
        check("cnt", bus.cnt, m_count[15:0]);
        check("err", bus.err, m_err);
        check("w_ack", bus_w.ack, m_ack);
        check("w_out_valid", bus_w.out_valid, m_valid);
        check("w_cnt", bus_w.cnt, m_count[1:0]);
    end

    logic [31:0] got_words[$];
    logic [1:0]  got_cnt_w[$];
    int          pulses = 0;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            got_words.push_back(bus.out);
            got_cnt_w.push_back(bus_w.cnt);
            pulses++;
        end
    end

    task automatic do_reset();
        req = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        got_words.delete();
        got_cnt_w.delete();
        pulses = 0;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (bus.ack !== lvl && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.ack, lvl);
    endtask

    task automatic send_word(input logic [31:0] w);
        data = w;
        req  = 1;
        wait_ack(1'b1, "send_ack_rise");
        req = 0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] exp_wrap [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (2) @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_out", bus.out, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_cnt", bus.cnt, 0);
        check("rst_err", bus.err, 0);
        rst = 0;

        // Single word: capture latency and ack release latency.
        @(negedge clk);
        data = 32'hDEADBEEF;
        req  = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_valid !== 1'b1 && n < 20);
        check("single_latency", n, 3);
        check("single_out", bus.out, 32'hDEADBEEF);
        check("single_ack", bus.ack, 1);
        check("single_cnt", bus.cnt, 1);
        @(negedge clk);
        check("single_valid_pulse", bus.out_valid, 0);
        req = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.ack !== 1'b0 && n < 20);
        check("single_ack_release", n, 3);

        // Back-to-back words.
        do_reset();
        send_word(32'h1);
        send_word(32'h2);
        send_word(32'h3);
        repeat (4) @(negedge clk);
        check("b2b_pulses", pulses, 3);
        check("b2b_word0", got_words[0], 32'h1);
        check("b2b_word1", got_words[1], 32'h2);
        check("b2b_word2", got_words[2], 32'h3);
        check("b2b_cnt", bus.cnt, 3);

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) send_word(32'h100 + i);
        repeat (4) @(negedge clk);
        check("wrap_pulses", pulses, 5);
        for (int i = 0; i < 5; i++) check($sformatf("wrap_cnt%0d", i), got_cnt_w[i], exp_wrap[i]);
        check("wrap_cnt16", bus.cnt, 5);

        // Reset mid-handshake with request still high: duplicate capture expected.
        do_reset();
        data = 32'hA5;
        req  = 1;
        wait_ack(1'b1, "midrst_ack");
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_ack0", bus.ack, 0);
        check("midrst_out0", bus.out, 0);
        check("midrst_valid0", bus.out_valid, 0);
        check("midrst_cnt0", bus.cnt, 0);
        check("midrst_err0", bus.err, 0);
        rst = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.out_valid !== 1'b1 && n < 20);
        check("midrst_latency", n, 3);
        check("midrst_out", bus.out, 32'hA5);
        check("midrst_cnt", bus.cnt, 1);
        req = 0;
        wait_ack(1'b0, "midrst_release");

`ifdef SYNC_RX_TIMEOUT_EN
        // Timeout: ack held exactly TO cycles, then STALL until req falls.
        do_reset();
        data = 32'h77;
        req  = 1;
        wait_ack(1'b1, "tmo_ack_rise");
        n = 0;
        while (bus.ack === 1'b1 && n < 50) begin n++; @(negedge clk); end
        check("tmo_ack_high_cycles", n, 8);
        check("tmo_err", bus.err, 1);
        repeat (20) @(negedge clk);
        check("tmo_stall_pulses", pulses, 1);
        check("tmo_stall_ack", bus.ack, 0);
        req = 0;
        repeat (4) @(negedge clk);
        send_word(32'h88);
        repeat (2) @(negedge clk);
        check("tmo_next_out", bus.out, 32'h88);
        check("tmo_next_cnt", bus.cnt, 2);
        check("tmo_err_sticky", bus.err, 1);
`else
        // No timeout: request held for a long time keeps ack high with one capture.
        do_reset();
        data = 32'h55;
        req  = 1;
        wait_ack(1'b1, "hold_ack_rise");
        repeat (10000) @(negedge clk);
        check("hold_pulses", pulses, 1);
        check("hold_ack", bus.ack, 1);
        check("hold_err", bus.err, 0);
        check("hold_out", bus.out, 32'h55);
        req = 0;
        wait_ack(1'b0, "hold_release");
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
